// File: rtl/key_mapping_if.sv
// -----------------------------------------------------------------------------
// key_mapping_if
// Groups the front-panel key-mapping signals into one bundle.
//   btn_bus    : debounced button levels [12:1], 1 = pressed
//   mode       : 1 = Morse, other values = normal
//   state      : upstream FSM state (carried, unused by the mapper)
//   dit_gap_ms : Morse dit length in ms (0 behaves as 1)
//   freeze     : 1 = suppress all key events
//   key_packet : {type[10:8], data[7:0]}, held between events
//   key_valid  : one-cycle strobe qualifying key_packet
// master = side that drives buttons/config, slave = the mapper.
// -----------------------------------------------------------------------------
interface key_mapping_if;
    logic [12:1] btn_bus;
    logic [1:0]  mode;
    logic [2:0]  state;
    logic [15:0] dit_gap_ms;
    logic        freeze;
    logic [10:0] key_packet;
    logic        key_valid;

    modport master (
        output btn_bus, mode, state, dit_gap_ms, freeze,
        input  key_packet, key_valid
    );

    modport slave (
        input  btn_bus, mode, state, dit_gap_ms, freeze,
        output key_packet, key_valid
    );
endinterface

// File: rtl/key_mapping.sv
// -----------------------------------------------------------------------------
// key_mapping
// Turns the 12 debounced buttons into single-cycle 11-bit key packets:
// Morse short/long on release, auto-repeating data keys, one-hot control keys.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, ACTIVE-HIGH (legacy name kept)
//   bus   : key_mapping_if.slave (buttons, mode, dit gap, freeze, packet out)
// -----------------------------------------------------------------------------
module key_mapping #(
    parameter int unsigned CLKS_PER_MS      = 100,
    parameter int unsigned REPEAT_DELAY_MS  = 300,
    parameter int unsigned REPEAT_PERIOD_MS = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    key_mapping_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_MORSE  = 2'd1,
        PRESS_REPEAT = 2'd2,
        PRESS_CTRL   = 2'd3
    } state_e;

    localparam int unsigned PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_MS - 1);

    state_e      st_q, st_d;
    logic [12:1] btn_q, btn_d;
    logic [12:1] btn_prev_q, btn_prev_d;
    logic        armed_q, armed_d;
    logic [12:1] active_mask_q, active_mask_d;
    logic [7:0]  active_data_q, active_data_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0] ms_q, ms_d;
    logic        first_rep_q, first_rep_d;
    logic [10:0] key_packet_q, key_packet_d;
    logic        key_valid_q, key_valid_d;

    logic [12:1] rise_s;
    logic [3:0]  sel_idx_s;
    logic        sel_found_s;
    logic        tick_s;
    logic        held_s;
    logic [15:0] held_ms_s;
    logic [15:0] dit_eff_s;
    logic [17:0] limit_s;
    logic [15:0] rep_target_s;
    logic        unused_s;

    assign unused_s = ^bus.state;

    // Lowest-index rising button among this cycle's edges.
    always_comb begin
        sel_idx_s   = 4'd0;
        sel_found_s = 1'b0;
        for (int i = 12; i >= 1; i--) begin
            if (rise_s[i]) begin
                sel_idx_s   = 4'(i);
                sel_found_s = 1'b1;
            end else begin
                sel_idx_s   = sel_idx_s;
            end
        end
    end

    // Edge detection, timebase and next-state / event generation.
    always_comb begin
        st_d          = st_q;
        btn_d         = bus.btn_bus;
        // First cycle after reset copies the live levels so a held button is not an edge.
        btn_prev_d    = armed_q ? btn_q : bus.btn_bus;
        armed_d       = 1'b1;
        active_mask_d = active_mask_q;
        active_data_d = active_data_q;
        first_rep_d   = first_rep_q;
        key_packet_d  = key_packet_q;
        key_valid_d   = 1'b0;

        rise_s = armed_q ? (btn_q & ~btn_prev_q) : 12'd0;
        held_s = |(btn_q & active_mask_q);

        tick_s  = (presc_q == PRESC_MAX);
        presc_d = tick_s ? '0 : presc_q + 1'b1;
        // held_ms_s is the ms count including a tick landing this cycle.
        if (tick_s && (ms_q != 16'hFFFF)) begin
            held_ms_s = ms_q + 16'd1;
        end else begin
            held_ms_s = ms_q;
        end
        ms_d = held_ms_s;

        dit_eff_s    = (bus.dit_gap_ms == 16'd0) ? 16'd1 : bus.dit_gap_ms;
        limit_s      = {2'b00, dit_eff_s} * 18'd3;
        rep_target_s = first_rep_q ? 16'(REPEAT_DELAY_MS) : 16'(REPEAT_PERIOD_MS);

        case (st_q)
            IDLE: begin
                if (sel_found_s && !bus.freeze) begin
                    active_mask_d = 12'd1 << (sel_idx_s - 4'd1);
                    presc_d       = '0;
                    ms_d          = 16'd0;
                    first_rep_d   = 1'b1;
                    if ((sel_idx_s == 4'd1) && (bus.mode == 2'd1)) begin
                        st_d = PRESS_MORSE;
                    end else if (sel_idx_s <= 4'd6) begin
                        st_d          = PRESS_REPEAT;
                        active_data_d = {4'd0, sel_idx_s};
                        key_packet_d  = {3'b000, 4'd0, sel_idx_s};
                        key_valid_d   = 1'b1;
                    end else begin
                        st_d         = PRESS_CTRL;
                        key_packet_d = {3'b100, 8'd1 << (sel_idx_s - 4'd7)};
                        key_valid_d  = 1'b1;
                    end
                end else begin
                    st_d = IDLE;
                end
            end
            PRESS_MORSE: begin
                if (!held_s) begin
                    st_d         = IDLE;
                    key_packet_d = ({2'b00, held_ms_s} < limit_s) ? 11'h001 : 11'h101;
                    key_valid_d  = 1'b1;
                end else begin
                    st_d = PRESS_MORSE;
                end
            end
            PRESS_REPEAT: begin
                // Release is checked first so it beats a repeat due this cycle.
                if (!held_s) begin
                    st_d = IDLE;
                end else if (tick_s && (held_ms_s == rep_target_s)) begin
                    ms_d         = 16'd0;
                    first_rep_d  = 1'b0;
                    key_packet_d = {3'b000, active_data_q};
                    key_valid_d  = 1'b1;
                end else begin
                    st_d = PRESS_REPEAT;
                end
            end
            PRESS_CTRL: begin
                if (!held_s) begin
                    st_d = IDLE;
                end else begin
                    st_d = PRESS_CTRL;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase

        if (bus.freeze) begin
            st_d         = IDLE;
            key_valid_d  = 1'b0;
            key_packet_d = key_packet_q;
        end else begin
            st_d = st_d;
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            st_q          <= IDLE;
            btn_q         <= 12'd0;
            btn_prev_q    <= 12'd0;
            armed_q       <= 1'b0;
            active_mask_q <= 12'd0;
            active_data_q <= 8'd0;
            presc_q       <= '0;
            ms_q          <= 16'd0;
            first_rep_q   <= 1'b0;
            key_packet_q  <= 11'd0;
            key_valid_q   <= 1'b0;
        end else begin
            st_q          <= st_d;
            btn_q         <= btn_d;
            btn_prev_q    <= btn_prev_d;
            armed_q       <= armed_d;
            active_mask_q <= active_mask_d;
            active_data_q <= active_data_d;
            presc_q       <= presc_d;
            ms_q          <= ms_d;
            first_rep_q   <= first_rep_d;
            key_packet_q  <= key_packet_d;
            key_valid_q   <= key_valid_d;
        end
    end

    assign bus.key_packet = key_packet_q;
    assign bus.key_valid  = key_valid_q;

endmodule

// File: tb/tb_key_mapping.sv
module tb_key_mapping;
    localparam int C = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [10:0] exp_q[$];
    int          pulse_t[$];

    key_mapping_if bus ();

    key_mapping #(.CLKS_PER_MS(C), .REPEAT_DELAY_MS(300), .REPEAT_PERIOD_MS(100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each strobe pops one expected packet.
    always @(negedge clk) begin
        if (bus.key_valid === 1'b1) begin
            pulse_t.push_back(cyc);
            if (exp_q.size() == 0)
                check_val("unexpected_pulse", {21'd0, bus.key_packet}, 32'hFFFF_FFFF);
            else
                check_val("packet", {21'd0, bus.key_packet}, {21'd0, exp_q.pop_front()});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drained(input string tag);
        step(8);
        check_val(tag, exp_q.size(), 0);
    endtask

    task automatic morse(input int ms, input logic [10:0] exp, input string tag);
        exp_q.push_back(exp);
        bus.btn_bus = 12'h001;
        step(ms * C);
        bus.btn_bus = 12'h000;
        drained(tag);
        step(5);
    endtask

    initial begin
        bus.btn_bus = 12'h002;
        bus.mode = 2'd1;
        bus.state = 3'd0;
        bus.dit_gap_ms = 16'd100;
        bus.freeze = 1'b0;
        rst_n = 1'b1;
        step(5);
        @(negedge clk);
        check_val("rst_valid", {31'd0, bus.key_valid}, 0);
        check_val("rst_packet", {21'd0, bus.key_packet}, 0);
        #1;
        rst_n = 1'b0;
        // btn 2 held through reset must not fire
        step(50);
        bus.btn_bus = 12'h000;
        drained("held_thru_reset");
        check_val("held_thru_reset_cnt", pulse_t.size(), 0);

        // Morse classification, dit 100 ms
        morse(100, 11'h001, "morse_100");
        morse(400, 11'h101, "morse_400");
        morse(300, 11'h101, "morse_300");
        morse(299, 11'h001, "morse_299");
        bus.dit_gap_ms = 16'd0;
        morse(2, 11'h001, "morse_dit0_2");
        morse(3, 11'h101, "morse_dit0_3");
        bus.dit_gap_ms = 16'd100;

        // Control keys
        bus.mode = 2'd0;
        pulse_t.delete();
        exp_q.push_back(11'h420);
        bus.btn_bus = 12'h800;
        step(100 * C);
        bus.btn_bus = 12'h000;
        drained("ctrl_12");
        exp_q.push_back(11'h401);
        bus.btn_bus = 12'h040;
        step(100 * C);
        bus.btn_bus = 12'h000;
        drained("ctrl_7");
        check_val("ctrl_cnt", pulse_t.size(), 2);

        // btn 1 in a normal mode is a data key
        bus.mode = 2'd2;
        exp_q.push_back(11'h001);
        bus.btn_bus = 12'h001;
        step(50 * C);
        bus.btn_bus = 12'h000;
        drained("btn1_normal");

        // Auto-repeat: 500 ms + a little -> 4 pulses
        pulse_t.delete();
        repeat (4) exp_q.push_back(11'h002);
        bus.btn_bus = 12'h002;
        step(500 * C + 5);
        bus.btn_bus = 12'h000;
        drained("repeat_500p");
        step(200 * C);
        check_val("repeat_cnt", pulse_t.size(), 4);
        if (pulse_t.size() == 4) begin
            check_val("rep_gap1", pulse_t[1] - pulse_t[0], 300 * C);
            check_val("rep_gap2", pulse_t[2] - pulse_t[1], 100 * C);
            check_val("rep_gap3", pulse_t[3] - pulse_t[2], 100 * C);
        end

        // Release exactly when a repeat is due -> release wins
        pulse_t.delete();
        repeat (3) exp_q.push_back(11'h002);
        bus.btn_bus = 12'h002;
        step(500 * C);
        bus.btn_bus = 12'h000;
        drained("repeat_500_exact");
        check_val("repeat_exact_cnt", pulse_t.size(), 3);

        // Simultaneous 3 and 5
        pulse_t.delete();
        exp_q.push_back(11'h003);
        bus.btn_bus = 12'h014;
        step(100 * C);
        bus.btn_bus = 12'h010;
        step(100 * C);
        bus.btn_bus = 12'h000;
        drained("simul_3");
        check_val("simul_cnt", pulse_t.size(), 1);
        exp_q.push_back(11'h005);
        bus.btn_bus = 12'h010;
        step(50 * C);
        bus.btn_bus = 12'h000;
        drained("repress_5");

        // Freeze during Morse press, and presses while frozen
        bus.mode = 2'd1;
        pulse_t.delete();
        bus.btn_bus = 12'h001;
        step(50 * C);
        bus.freeze = 1'b1;
        step(20 * C);
        bus.btn_bus = 12'h009;
        step(20 * C);
        bus.freeze = 1'b0;
        step(20 * C);
        bus.btn_bus = 12'h000;
        step(50 * C);
        check_val("freeze_cnt", pulse_t.size(), 0);

        // Reset in the middle of a repeat
        bus.mode = 2'd0;
        pulse_t.delete();
        exp_q.push_back(11'h002);
        exp_q.push_back(11'h002);
        bus.btn_bus = 12'h002;
        step(350 * C);
        check_val("pre_reset_cnt", pulse_t.size(), 2);
        rst_n = 1'b1;
        step(3);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_valid", {31'd0, bus.key_valid}, 0);
        check_val("midrst_packet", {21'd0, bus.key_packet}, 0);
        #1;
        step(400 * C);
        bus.btn_bus = 12'h000;
        drained("mid_reset");
        check_val("post_reset_cnt", pulse_t.size(), 2);
        check_val("post_reset_packet", {21'd0, bus.key_packet}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
